// File: rtl/keyboard_event_decoder.sv
// keyboard_event_decoder: PS/2 frame receiver and scan-code decoder with per-key state; PS2_PARITY_CHECK_EN enables frame rejection
module keyboard_event_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic         frame_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, dat_sync;
  logic clk_f, d, fall, timeout, done, accept, ext, brk;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  assign d = dat_sync[1];
`ifdef PS2_PARITY_CHECK_EN
  logic par_ok;
  always_ff @(posedge clk)
    if (rst) par_ok <= 1'b0;
    else if (fall && state == PARITY) par_ok <= ^{shift, d};
  assign accept = par_ok & d;
`else
  assign accept = 1'b1;
`endif
  always_comb begin
    fall = clk_f & ~clk_sync[1] & (flt_cnt == FW'(FILTER_LEN - 1));
    timeout = (state != IDLE) & ~fall & (to_cnt == TW'(TIMEOUT_CYCLES));
    done = fall & (state == STOP);
    state_n = timeout ? IDLE :
              !fall ? state :
              state == IDLE ? (d ? IDLE : DATA) :
              state == DATA ? (bit_cnt == 3'd7 ? PARITY : DATA) :
              state == PARITY ? STOP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f <= 1'b1;
      flt_cnt <= '0;
      to_cnt <= '0;
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      key_down <= '0;
      last_change <= '0;
      been_ready <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      flt_cnt <= (clk_sync[1] == clk_f || flt_cnt == FW'(FILTER_LEN - 1)) ? '0 : flt_cnt + FW'(1);
      if (clk_sync[1] != clk_f && flt_cnt == FW'(FILTER_LEN - 1)) clk_f <= clk_sync[1];
      to_cnt <= (fall || state == IDLE) ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES) ? to_cnt : to_cnt + TW'(1));
      state <= state_n;
      been_ready <= 1'b0;
      frame_err <= 1'b0;
      if (fall && state == DATA) begin
        shift <= {d, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // an abandoned frame must not leak prefix state into the next one
      if (timeout) begin
        shift <= '0;
        bit_cnt <= '0;
        ext <= 1'b0;
        brk <= 1'b0;
      end
      if (done) begin
        if (!accept) begin
          frame_err <= 1'b1;
          ext <= 1'b0;
          brk <= 1'b0;
        end else if (shift == 8'hE0) ext <= 1'b1;
        else if (shift == 8'hF0) brk <= 1'b1;
        else if (shift == 8'hE1) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else begin
          key_down[{ext, shift}] <= ~brk;
          last_change <= {ext, shift};
          been_ready <= 1'b1;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_keyboard_event_decoder.sv
// tb_keyboard_event_decoder: directed PS/2 frames checked against a scan-code model every cycle
module tb_keyboard_event_decoder;
  localparam int FL = 8, TO = 500, HALF = 20;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [511:0] key_down;
  logic [8:0] last_change;
  logic been_ready, frame_err;
  typedef struct {logic [8:0] code; logic val;} ev_t;
  ev_t exp_q[$];
  logic [511:0] mk = '0;
  logic m_ext = 0, m_brk = 0;
  int exp_err = 0, cyc = 0, stop_cyc = 0, n_chk = 0, n_fail = 0, br_cnt = 0, err_cnt = 0;
  int b0, e0;

  keyboard_event_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_down(key_down), .last_change(last_change), .been_ready(been_ready), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [511:0] act, logic [511:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic flag(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (been_ready === 1'b1) begin
        br_cnt++;
        if (exp_q.size() == 0) flag("unexpected_been_ready");
        else begin
          e = exp_q.pop_front();
          mk[e.code] = e.val;
          chk("last_change", last_change, e.code);
          chk("event_latency", cyc - stop_cyc, FL + 2);
        end
      end else chk("been_ready_low", been_ready, 0);
      if (frame_err === 1'b1) begin
        err_cnt++;
        if (exp_err == 0) flag("unexpected_frame_err");
        else begin
          exp_err--;
          chk("err_latency", cyc - stop_cyc, FL + 2);
        end
      end else chk("frame_err_low", frame_err, 0);
      chk("key_down", key_down, mk);
    end
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(logic [7:0] b, logic good);
`ifdef PS2_PARITY_CHECK_EN
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
      return;
    end
`endif
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      exp_q.push_back('{code: {m_ext, b}, val: ~m_brk});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bit(logic b, logic is_stop);
    ps2_data = b;
    wait_n(HALF);
    ps2_clk = 0;
    if (is_stop) stop_cyc = cyc;
    wait_n(HALF);
    ps2_clk = 1;
  endtask

  task automatic send_frame(logic [7:0] b, logic bad_par);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(~^b ^ bad_par, 1'b0);
    model_frame(b, ~bad_par);
    send_bit(1'b1, 1'b1);
    wait_n(HALF);
  endtask

  task automatic drain();
    wait_n(5);
    n_chk++;
    if (exp_q.size() != 0 || exp_err != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d events and %0d errors never seen", exp_q.size(), exp_err);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    mk = '0;
    m_ext = 0;
    m_brk = 0;
    exp_q.delete();
    exp_err = 0;
    wait_n(2);
    rst = 0;
  endtask

  task automatic chk_zero();
    chk("rst_key_down", key_down, 0);
    chk("rst_last_change", last_change, 0);
    chk("rst_been_ready", been_ready, 0);
    chk("rst_frame_err", frame_err, 0);
  endtask

  initial begin
    do_reset();
    wait_n(2);
    chk_zero();
    b0 = br_cnt;
    send_frame(8'h1C, 0);
    drain();
    chk("make_1c", key_down[9'h01C], 1);
    chk("make_1c_code", last_change, 9'h01C);
    chk("make_1c_pulses", br_cnt - b0, 1);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain();
    chk("break_1c", key_down[9'h01C], 0);
    chk("break_1c_code", last_change, 9'h01C);
    chk("break_1c_pulses", br_cnt - b0, 2);
    b0 = br_cnt;
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    drain();
    chk("ext_make_175", key_down[9'h175], 1);
    chk("ext_make_075", key_down[9'h075], 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    drain();
    chk("ext_break_175", key_down[9'h175], 0);
    chk("ext_break_075", key_down[9'h075], 0);
    chk("ext_pulses", br_cnt - b0, 2);
    b0 = br_cnt;
    send_frame(8'h1C, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h2A, 0);
    drain();
    chk("typematic_1c", key_down[9'h01C], 1);
    chk("break_unpressed_2a", key_down[9'h02A], 0);
    chk("break_unpressed_code", last_change, 9'h02A);
    chk("typematic_pulses", br_cnt - b0, 3);
    send_frame(8'hE0, 0);
    send_frame(8'hE1, 0);
    send_frame(8'h16, 0);
    drain();
    chk("e1_clears_code", last_change, 9'h016);
    chk("e1_clears_ext", key_down[9'h116], 0);
    b0 = br_cnt;
    e0 = err_cnt;
    send_frame(8'h23, 1);
    drain();
`ifdef PS2_PARITY_CHECK_EN
    chk("bad_par_err", err_cnt - e0, 1);
    chk("bad_par_no_event", br_cnt - b0, 0);
    chk("bad_par_key", key_down[9'h023], 0);
`else
    chk("bad_par_err", err_cnt - e0, 0);
    chk("bad_par_event", br_cnt - b0, 1);
    chk("bad_par_key", key_down[9'h023], 1);
`endif
    send_frame(8'hE0, 0);
    b0 = br_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    wait_n(TO + 10);
    m_ext = 0;
    m_brk = 0;
    chk("timeout_no_event", br_cnt - b0, 0);
    send_frame(8'h1D, 0);
    drain();
    chk("timeout_key_01d", key_down[9'h01D], 1);
    chk("timeout_key_11d", key_down[9'h11D], 0);
    chk("timeout_code", last_change, 9'h01D);
    b0 = br_cnt;
    ps2_data = 0;
    ps2_clk = 0;
    wait_n(3);
    ps2_clk = 1;
    ps2_data = 1;
    wait_n(30);
    send_frame(8'h1B, 0);
    drain();
    chk("glitch_code", last_change, 9'h01B);
    chk("glitch_pulses", br_cnt - b0, 1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    do_reset();
    wait_n(1);
    chk_zero();
    b0 = br_cnt;
    send_frame(8'h1C, 0);
    drain();
    chk("post_rst_key", key_down[9'h01C], 1);
    chk("post_rst_pulses", br_cnt - b0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
